// File: rtl/mem_access_seq_if.sv
// Bundle of pipeline-request and byte-memory signals around the word-to-byte access sequencer.
// The sequencer binds to the slave modport; the pipeline/memory side binds to master.
interface mem_access_seq_if;
  logic        req_read_i;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [7:0]  mem_rdata_i;

  modport slave (
    input  req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output stall_o, done_o, err_o, rdata_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

  modport master (
    output req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  stall_o, done_o, err_o, rdata_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/mem_access_seq.sv
// Splits a word lw/sw into four little-endian byte accesses on a byte-wide data memory,
// assembles load data and stalls the pipeline until the access completes.
//
// state   | meaning
// IDLE    | waiting for a request; stall follows the request combinationally
// WR      | one byte write strobe per beat, beats 0..3
// RD      | one byte read strobe per beat; captures the byte read on the previous beat
// RD_TAIL | captures the last byte and loads rdata_o
// DONE    | completion pulse, request inputs ignored
// ERR     | completion plus error pulse, no memory activity
module mem_access_seq #(
  parameter int MEM_BYTES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_access_seq_if.slave bus
);

  localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [1:0]  next_beat;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [23:0] asm_q;
  logic [31:0] rdata_q;
  logic        stall_q;
  logic        done_q;
  logic        err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        req_valid;
  logic        req_bad;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  always_comb begin
    next_beat = beat + 2'd1;
    req_valid = bus.req_read_i | bus.req_write_i;
    req_bad   = (bus.req_read_i & bus.req_write_i) | (bus.req_addr_i[1:0] != 2'b00) |
                (bus.req_addr_i > MAX_BASE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      beat        <= 2'd0;
      base        <= '0;
      wdata       <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base  <= bus.req_addr_i;
            wdata <= bus.req_wdata_i;
            beat  <= 2'd0;
            if (req_bad) begin
              state  <= ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.req_write_i) begin
              state       <= WR;
              stall_q     <= 1'b1;
              mem_write_q <= 1'b1;
              mem_addr_q  <= bus.req_addr_i;
              mem_wdata_q <= bus.req_wdata_i[7:0];
            end else begin
              state      <= RD;
              stall_q    <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= bus.req_addr_i;
            end
          end
        end
        WR: begin
          if (beat == 2'd3) begin
            state   <= DONE;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            beat        <= next_beat;
            mem_write_q <= 1'b1;
            mem_addr_q  <= base + {30'd0, next_beat};
            mem_wdata_q <= byte_of(wdata, next_beat);
          end
        end
        RD: begin
          // memory data lags the strobe by one cycle, so beat k lands byte k-1
          case (beat)
            2'd1:    asm_q[7:0]   <= bus.mem_rdata_i;
            2'd2:    asm_q[15:8]  <= bus.mem_rdata_i;
            2'd3:    asm_q[23:16] <= bus.mem_rdata_i;
            default: ;
          endcase
          if (beat == 2'd3) begin
            state <= RD_TAIL;
          end else begin
            beat       <= next_beat;
            mem_read_q <= 1'b1;
            mem_addr_q <= base + {30'd0, next_beat};
          end
        end
        RD_TAIL: begin
          rdata_q <= {bus.mem_rdata_i, asm_q};
          state   <= DONE;
          stall_q <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o     = stall_q | ((state == IDLE) & req_valid);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.mem_read_o  = mem_read_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq with a registered byte-memory model attached.
module tb_mem_access_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  mem_access_seq_if bus();

  mem_access_seq #(.MEM_BYTES(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:31] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.mem_write_o && bus.mem_addr_o < 32) mem[bus.mem_addr_o[4:0]] <= bus.mem_wdata_o;
    if (bus.mem_read_o && bus.mem_addr_o < 32) bus.mem_rdata_i <= mem[bus.mem_addr_o[4:0]];
  end

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_read_i  = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'hFFFF_FFF3;
    bus.req_wdata_i = 32'h5A5A_5A5A;
  endtask

  task automatic do_write(input string t, input logic [31:0] a, input logic [31:0] d);
    next_cycle();
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    @(negedge clk);
    chk_b({t, "_c0_stall"}, bus.stall_o, 1'b1);
    chk_b({t, "_c0_nowr"}, bus.mem_write_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) idle_req();
      @(negedge clk);
      chk_b({t, "_wr_strobe"}, bus.mem_write_o, 1'b1);
      chk_b({t, "_wr_nord"}, bus.mem_read_o, 1'b0);
      chk_w({t, "_wr_addr"}, bus.mem_addr_o, a + 32'(k));
      chk_w({t, "_wr_byte"}, {24'd0, bus.mem_wdata_o}, {24'd0, d[8*k +: 8]});
      chk_b({t, "_wr_stall"}, bus.stall_o, 1'b1);
      chk_b({t, "_wr_nodone"}, bus.done_o, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    chk_b({t, "_c5_done"}, bus.done_o, 1'b1);
    chk_b({t, "_c5_noerr"}, bus.err_o, 1'b0);
    chk_b({t, "_c5_stall"}, bus.stall_o, 1'b0);
    chk_b({t, "_c5_nowr"}, bus.mem_write_o, 1'b0);
  endtask

  task automatic do_read(input string t, input logic [31:0] a, input logic [31:0] exp);
    next_cycle();
    bus.req_read_i = 1'b1;
    bus.req_addr_i = a;
    @(negedge clk);
    chk_b({t, "_c0_stall"}, bus.stall_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) idle_req();
      @(negedge clk);
      chk_b({t, "_rd_strobe"}, bus.mem_read_o, 1'b1);
      chk_b({t, "_rd_nowr"}, bus.mem_write_o, 1'b0);
      chk_w({t, "_rd_addr"}, bus.mem_addr_o, a + 32'(k));
      chk_b({t, "_rd_stall"}, bus.stall_o, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    chk_b({t, "_c5_nord"}, bus.mem_read_o, 1'b0);
    chk_b({t, "_c5_stall"}, bus.stall_o, 1'b1);
    chk_b({t, "_c5_nodone"}, bus.done_o, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_b({t, "_c6_done"}, bus.done_o, 1'b1);
    chk_b({t, "_c6_noerr"}, bus.err_o, 1'b0);
    chk_b({t, "_c6_stall"}, bus.stall_o, 1'b0);
    chk_w({t, "_c6_rdata"}, bus.rdata_o, exp);
  endtask

  task automatic do_err(input string t, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] keep);
    next_cycle();
    bus.req_read_i  = rd;
    bus.req_write_i = wr;
    bus.req_addr_i  = a;
    bus.req_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk_b({t, "_c0_stall"}, bus.stall_o, 1'b1);
    next_cycle();
    idle_req();
    @(negedge clk);
    chk_b({t, "_c1_done"}, bus.done_o, 1'b1);
    chk_b({t, "_c1_err"}, bus.err_o, 1'b1);
    chk_b({t, "_c1_stall"}, bus.stall_o, 1'b0);
    chk_b({t, "_c1_nowr"}, bus.mem_write_o, 1'b0);
    chk_b({t, "_c1_nord"}, bus.mem_read_o, 1'b0);
    chk_w({t, "_c1_rdata"}, bus.rdata_o, keep);
    next_cycle();
    @(negedge clk);
    chk_b({t, "_c2_nodone"}, bus.done_o, 1'b0);
    chk_b({t, "_c2_nostrobe"}, bus.mem_write_o | bus.mem_read_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1);
  end

  initial begin
    idle_req();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_b("rst_stall", bus.stall_o, 1'b0);
    chk_b("rst_done", bus.done_o, 1'b0);
    chk_b("rst_err", bus.err_o, 1'b0);
    chk_b("rst_rd", bus.mem_read_o, 1'b0);
    chk_b("rst_wr", bus.mem_write_o, 1'b0);
    chk_w("rst_rdata", bus.rdata_o, 32'h0);

    do_write("t1", 32'd8, 32'hDEADBEEF);
    chk_w("t1_mem8", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
    do_read("t2", 32'd8, 32'hDEADBEEF);

    do_write("t3w", 32'd28, 32'h01020304);
    do_read("t3r", 32'd28, 32'h01020304);
    do_err("t3_mis30", 1'b0, 1'b1, 32'd30, 32'h01020304);
    do_err("t3_oor32", 1'b1, 1'b0, 32'd32, 32'h01020304);
    do_err("t4_both", 1'b1, 1'b1, 32'd4, 32'h01020304);
    chk_w("t4_mem4", {mem[7], mem[6], mem[5], mem[4]}, 32'h0);

    // reset lands in cycle 3 of a write; beat 2 strobe still commits
    next_cycle();
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'd16;
    bus.req_wdata_i = 32'hAABBCCDD;
    @(negedge clk);
    chk_b("t5_c0_stall", bus.stall_o, 1'b1);
    next_cycle();
    idle_req();
    @(negedge clk);
    chk_w("t5_c1_addr", bus.mem_addr_o, 32'd16);
    next_cycle();
    @(negedge clk);
    chk_b("t5_c2_nodone", bus.done_o, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk_b("t5_c3_wr", bus.mem_write_o, 1'b1);
    chk_w("t5_c3_addr", bus.mem_addr_o, 32'd18);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_b("t5_c4_done", bus.done_o, 1'b0);
    chk_b("t5_c4_stall", bus.stall_o, 1'b0);
    chk_b("t5_c4_strobe", bus.mem_write_o | bus.mem_read_o, 1'b0);
    chk_w("t5_c4_addr", bus.mem_addr_o, 32'd0);
    chk_w("t5_c4_rdata", bus.rdata_o, 32'd0);
    chk_w("t5_mem16", {mem[19], mem[18], mem[17], mem[16]}, 32'h00BBCCDD);
    next_cycle();
    @(negedge clk);
    chk_b("t5_c5_nodone", bus.done_o, 1'b0);
    chk_w("t5_mem16_hold", {mem[19], mem[18], mem[17], mem[16]}, 32'h00BBCCDD);

    do_write("t6w", 32'd0, 32'h11223344);
    do_read("t6r", 32'd0, 32'h11223344);
    chk_w("t6_mem0", {mem[3], mem[2], mem[1], mem[0]}, 32'h11223344);
    next_cycle();
    @(negedge clk);
    chk_b("t6_after_done", bus.done_o, 1'b0);
    chk_b("t6_after_stall", bus.stall_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
